// File: rtl/toggle_pkg.sv
// Shared types for the debounced toggle-strobe generator.
package toggle_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM_HI = 2'd1,
    HIGH   = 2'd2,
    ARM_LO = 2'd3
  } tstate_e;

  localparam int CNT_MAX_DEF = 4;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/toggle_pulse_gen.sv
// Debounces a bouncy push-button and issues one registered T strobe per accepted press.
module toggle_pulse_gen
  import toggle_pkg::*;
#(
  parameter int CNT_MAX = CNT_MAX_DEF,
  parameter int CNT_W   = $clog2(CNT_MAX + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  output logic       t_out,
  output logic       btn_level,
  output logic [7:0] press_count
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             btn_s;
  tstate_e          state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             pulse_nx;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (btn_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      t_out       <= 1'b0;
      btn_level   <= 1'b0;
      press_count <= 8'd0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      t_out       <= pulse_nx;
      btn_level   <= (state_nx == HIGH) || (state_nx == ARM_LO);
      press_count <= press_count + 8'(pulse_nx);
    end
  end

  // ARM_* states count consecutive agreeing samples; any disagreement falls back.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pulse_nx = 1'b0;
    case (state)
      IDLE: begin
        if (btn_s) begin
          state_nx = ARM_HI;
          cnt_nx   = CNT_ONE;
        end else begin
          cnt_nx   = '0;
        end
      end
      ARM_HI: begin
        if (!btn_s) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nx = HIGH;
          cnt_nx   = '0;
          pulse_nx = 1'b1;
        end else begin
          cnt_nx   = cnt + CNT_ONE;
        end
      end
      HIGH: begin
        if (!btn_s) begin
          state_nx = ARM_LO;
          cnt_nx   = CNT_ONE;
        end else begin
          cnt_nx   = '0;
        end
      end
      ARM_LO: begin
        if (btn_s) begin
          state_nx = HIGH;
          cnt_nx   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx   = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_toggle_pulse_gen.sv
// Bench for toggle_pulse_gen: vector table plus hand-written reset/release/wrap sequences.
module tb_toggle_pulse_gen;

  localparam int CM = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_in = 1'b0;
  logic       t_out;
  logic       btn_level;
  logic [7:0] press_count;

  int chk = 0;
  int err = 0;
  int cyc = 0;
  logic [7:0] exp_cnt = 8'd0;

  int exp_q[$];
  int obs_q[$];

  typedef struct {
    string       name;
    logic [63:0] pat;
    int          len;
    int          pulse_off;
    int          lvl_off;
    logic        lvl_exp;
  } vec_t;

  vec_t vecs[4];

  toggle_pulse_gen #(.CNT_MAX(CM)) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_in      (btn_in),
    .t_out       (t_out),
    .btn_level   (btn_level),
    .press_count (press_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Each observed strobe is logged with the edge that produced it.
  always @(negedge clk) if (t_out !== 1'b0) obs_q.push_back(cyc);

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick(input logic b, input logic r);
    btn_in = b;
    rst    = r;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string nm);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      int e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      check({nm, "_pulse_edge"}, o, e);
    end
    check({nm, "_missing_pulses"}, exp_q.size(), 0);
    check({nm, "_extra_pulses"}, obs_q.size(), 0);
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    int base, r;

    vecs[0] = '{"clean",  64'h0000_0000_000F_FFFF, 32, 6,  6, 1'b1};
    vecs[1] = '{"bounce", 64'h0000_0000_00AF_FFF5, 36, 10, 9, 1'b0};
    vecs[2] = '{"glitch3", 64'h7,                  13, 0,  6, 1'b0};
    vecs[3] = '{"min4",   64'hF,                   16, 6,  6, 1'b1};

    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    check("rst_t_out", t_out, 0);
    check("rst_level", btn_level, 0);
    check("rst_count", press_count, 0);
    obs_q.delete();

    foreach (vecs[v]) begin
      base = cyc;
      if (vecs[v].pulse_off > 0) begin
        exp_q.push_back(base + vecs[v].pulse_off);
        exp_cnt++;
      end
      for (int i = 0; i < vecs[v].len; i++) begin
        tick(vecs[v].pat[i], 1'b0);
        if (i + 1 == vecs[v].lvl_off) check({vecs[v].name, "_level"}, btn_level, vecs[v].lvl_exp);
      end
      check({vecs[v].name, "_end_level"}, btn_level, 0);
      check({vecs[v].name, "_count"}, press_count, exp_cnt);
      drain(vecs[v].name);
    end

    // Reset while qualifying a rise, button held throughout.
    base = cyc;
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    r = cyc;
    exp_cnt = 8'd0;
    check("rstq_t_out", t_out, 0);
    check("rstq_level", btn_level, 0);
    check("rstq_count", press_count, 0);
    exp_q.push_back(r + CM + 2);
    exp_cnt++;
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b0);
    check("rstq_level_hi", btn_level, 1);
    check("rstq_count_after", press_count, exp_cnt);
    for (int i = 0; i < 12; i++) tick(1'b0, 1'b0);
    drain("rst_qualify");

    // Reset on the very edge a strobe is due; it must be suppressed.
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    r = cyc;
    exp_cnt = 8'd0;
    check("rstdue_t_out", t_out, 0);
    check("rstdue_count", press_count, 0);
    exp_q.push_back(r + CM + 2);
    exp_cnt++;
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b0);
    for (int i = 0; i < 12; i++) tick(1'b0, 1'b0);
    check("rstdue_count_after", press_count, exp_cnt);
    drain("rst_due");

    // Long hold, bouncy release: level falls only after the stable low qualifies.
    base = cyc;
    exp_q.push_back(base + CM + 2);
    exp_cnt++;
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    for (int j = 0; j < 12; j++) begin
      tick(1'b0, 1'b0);
      if (j == CM)     check("release_level_held", btn_level, 1);
      if (j == CM + 2) check("release_level_fell", btn_level, 0);
    end
    check("release_count", press_count, exp_cnt);
    drain("release");

    // 256 clean presses from a cleared counter: the last one wraps 255 -> 0.
    tick(1'b0, 1'b1);
    exp_cnt = 8'd0;
    obs_q.delete();
    for (int p = 0; p < 256; p++) begin
      base = cyc;
      exp_q.push_back(base + CM + 2);
      exp_cnt++;
      for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
      for (int i = 0; i < 7; i++) tick(1'b0, 1'b0);
      check($sformatf("wrap_count_%0d", p), press_count, exp_cnt);
      drain("wrap");
    end
    check("wrap_final_zero", press_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", chk, err);
    $finish;
  end

endmodule
